// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the CPU load/store path, the external loader/debug path
// and the shared data memory. The arbiter uses the slave view.
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          ext_req;
    logic          ext_we;
    logic          ext_lock;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          locked;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output locked
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_lock, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  locked
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, EXT gets a starvation
// override and can lock the port for bursts. Read data returns one cycle after grant.
module dmem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_port_arbiter_if.slave bus
);
    typedef enum logic {
        ARB      = 1'b0,
        EXT_LOCK = 1'b1
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    state_t     stateNext;
    logic [3:0] waitCnt;
    logic       cpuGnt;
    logic       extGnt;
    logic       rdPend_p1;
    logic       rdOwnerExt_p1;
    logic       rdIssue;

    // Grants are forced low during reset so every output reads 0.
    always_comb begin
        cpuGnt    = 1'b0;
        extGnt    = 1'b0;
        stateNext = state;
        if (!reset) begin
            case (state)
                ARB: begin
                    if (bus.ext_req && (!bus.cpu_req || waitCnt == LIMIT)) begin
                        extGnt = 1'b1;
                    end else if (bus.cpu_req) begin
                        cpuGnt = 1'b1;
                    end
                    if (extGnt && bus.ext_lock) begin
                        stateNext = EXT_LOCK;
                    end
                end
                EXT_LOCK: begin
                    extGnt = bus.ext_req;
                    if (!bus.ext_lock) begin
                        stateNext = ARB;
                    end
                end
                default: stateNext = ARB;
            endcase
        end
    end

    assign bus.cpu_gnt   = cpuGnt;
    assign bus.ext_gnt   = extGnt;
    assign bus.mem_en    = cpuGnt | extGnt;
    assign bus.mem_we    = (cpuGnt & bus.cpu_we) | (extGnt & bus.ext_we);
    assign bus.mem_addr  = cpuGnt ? bus.cpu_addr  : (extGnt ? bus.ext_addr  : '0);
    assign bus.mem_wdata = cpuGnt ? bus.cpu_wdata : (extGnt ? bus.ext_wdata : '0);
    assign bus.locked    = (state == EXT_LOCK);
    assign rdIssue       = bus.mem_en & ~bus.mem_we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= stateNext;
        end
    end

    // Stage p0 -> p1: grant accepted, memory read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt       <= 4'd0;
            rdPend_p1     <= 1'b0;
            rdOwnerExt_p1 <= 1'b0;
        end else begin
            if (!bus.ext_req || extGnt) begin
                waitCnt <= 4'd0;
            end else if (waitCnt != LIMIT) begin
                waitCnt <= waitCnt + 4'd1;
            end
            rdPend_p1 <= rdIssue;
            if (rdIssue) begin
                rdOwnerExt_p1 <= extGnt;
            end
        end
    end

    assign bus.cpu_rvalid = rdPend_p1 & ~rdOwnerExt_p1;
    assign bus.ext_rvalid = rdPend_p1 &  rdOwnerExt_p1;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.ext_rdata  = bus.ext_rvalid ? bus.mem_rdata : '0;
endmodule
